cache_opr_done_tracker: RTL



---
 rtl/cache_opr_done_tracker_if.sv | 30 +++
 rtl/cache_opr_done_tracker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cache_opr_done_tracker_if.sv
// Sequencing bus between the cache operation controller/operation units
// (master) and the done tracker (slave).
interface cache_opr_done_tracker_if #(
  parameter int unsigned NUM_OPR = 8,
  parameter int unsigned LAT_W   = 10
);
  logic [NUM_OPR-1:0] opr_start;
  logic [NUM_OPR-1:0] opr_done;
  logic               clr_err;
  logic               opr_finished;
  logic               busy;
  logic [3:0]         cur_stage;
  logic [NUM_OPR-1:0] done_mask;
  logic               seq_err;
  logic               timeout_err;
  logic [LAT_W-1:0]   last_latency;
  logic [LAT_W-1:0]   max_latency;

  modport master (
    output opr_start, opr_done, clr_err,
    input  opr_finished, busy, cur_stage, done_mask, seq_err, timeout_err,
           last_latency, max_latency
  );

  modport slave (
    input  opr_start, opr_done, clr_err,
    output opr_finished, busy, cur_stage, done_mask, seq_err, timeout_err,
           last_latency, max_latency
  );
endinterface

// File: rtl/cache_opr_done_tracker.sv
// Cache operation done tracker: follows the stage start/done handshake in
// strict order, watches every stage for timeout and pulses opr_finished when
// the sequence completes or aborts.
// Optional latency statistics: define OPR_LAT_STATS_EN.
module cache_opr_done_tracker #(
  parameter int unsigned NUM_OPR     = 8,
  parameter int unsigned TIMEOUT_CYC = 32,
  parameter int unsigned TMR_W       = 6,
  parameter int unsigned LAT_W       = 10
) (
  input logic                     clk,
  input logic                     rstb,
  cache_opr_done_tracker_if.slave bus
);
  localparam int unsigned STG_W = 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_FIN  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [STG_W-1:0]   stage_q, stage_d;
  logic [NUM_OPR-1:0] mask_q, mask_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               fin_q, fin_d;
  logic               busy_q, busy_d;
  logic               seq_err_q, seq_err_d;
  logic               to_err_q, to_err_d;

  logic [NUM_OPR-1:0] cur_oh;
  logic [NUM_OPR-1:0] nxt_oh;
  logic               is_last;
  logic               nxt_last;
  logic               tmr_exp;
  logic               seq_hit;
  logic               to_hit;

  assign cur_oh   = NUM_OPR'(1) << stage_q;
  assign nxt_oh   = NUM_OPR'(1) << (stage_q + STG_W'(1));
  assign is_last  = (stage_q == STG_W'(NUM_OPR - 1));
  assign nxt_last = (stage_q == STG_W'(NUM_OPR - 2));
  assign tmr_exp  = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));

  // Next-state: ordering checks take priority over progress, progress over timeout.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    mask_d  = mask_q;
    tmr_d   = (tmr_q == '1) ? tmr_q : tmr_q + TMR_W'(1);
    seq_hit = 1'b0;
    to_hit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (bus.opr_start == NUM_OPR'(1)) begin
          stage_d = '0;
          mask_d  = '0;
          if (bus.opr_done[0]) begin
            mask_d[0] = 1'b1;
            state_d   = (NUM_OPR == 1) ? S_FIN : S_GAP;
          end else begin
            state_d = S_RUN;
          end
        end else if (bus.opr_start != '0) begin
          seq_hit = 1'b1;
        end
      end
      S_RUN: begin
        if ((bus.opr_start != '0) || ((bus.opr_done & ~cur_oh) != '0)) begin
          seq_hit = 1'b1;
          state_d = S_ERR;
        end else if ((bus.opr_done & cur_oh) != '0) begin
          mask_d  = mask_q | cur_oh;
          tmr_d   = '0;
          state_d = is_last ? S_FIN : S_GAP;
        end else if (tmr_exp) begin
          to_hit  = 1'b1;
          state_d = S_ERR;
        end
      end
      S_GAP: begin
        // A done in GAP is legal only together with the matching next start.
        if (((bus.opr_start & ~nxt_oh) != '0) ||
            ((bus.opr_done & ~(bus.opr_start & nxt_oh)) != '0)) begin
          seq_hit = 1'b1;
          state_d = S_ERR;
        end else if ((bus.opr_start & nxt_oh) != '0) begin
          stage_d = stage_q + STG_W'(1);
          tmr_d   = '0;
          if ((bus.opr_done & nxt_oh) != '0) begin
            mask_d  = mask_q | nxt_oh;
            state_d = nxt_last ? S_FIN : S_GAP;
          end else begin
            state_d = S_RUN;
          end
        end else if (tmr_exp) begin
          to_hit  = 1'b1;
          state_d = S_ERR;
        end
      end
      S_FIN, S_ERR: begin
        tmr_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        tmr_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    fin_d     = (state_d == S_FIN) || (state_d == S_ERR);
    busy_d    = (state_d == S_RUN) || (state_d == S_GAP);
    seq_err_d = (seq_err_q & ~bus.clr_err) | seq_hit;
    to_err_d  = (to_err_q & ~bus.clr_err) | to_hit;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= S_IDLE;
      stage_q   <= '0;
      mask_q    <= '0;
      tmr_q     <= '0;
      fin_q     <= 1'b0;
      busy_q    <= 1'b0;
      seq_err_q <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      mask_q    <= mask_d;
      tmr_q     <= tmr_d;
      fin_q     <= fin_d;
      busy_q    <= busy_d;
      seq_err_q <= seq_err_d;
      to_err_q  <= to_err_d;
    end
  end

  assign bus.opr_finished = fin_q;
  assign bus.busy         = busy_q;
  assign bus.cur_stage    = stage_q;
  assign bus.done_mask    = mask_q;
  assign bus.seq_err      = seq_err_q;
  assign bus.timeout_err  = to_err_q;

`ifdef OPR_LAT_STATS_EN
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [LAT_W-1:0] last_q, last_d;
  logic [LAT_W-1:0] max_q, max_d;

  // Latency counts the first active cycle through the FIN cycle; errors publish nothing.
  always_comb begin
    lat_d  = lat_q;
    last_d = last_q;
    max_d  = max_q;
    if (state_q == S_IDLE) begin
      if (state_d != S_IDLE) lat_d = LAT_W'(1);
    end else if ((state_q == S_RUN) || (state_q == S_GAP)) begin
      lat_d = (lat_q == '1) ? lat_q : lat_q + LAT_W'(1);
    end
    if (state_d == S_FIN) begin
      last_d = lat_d;
      if (lat_d > max_q) max_d = lat_d;
    end
  end

  // Latency statistics registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      lat_q  <= '0;
      last_q <= '0;
      max_q  <= '0;
    end else begin
      lat_q  <= lat_d;
      last_q <= last_d;
      max_q  <= max_d;
    end
  end

  assign bus.last_latency = last_q;
  assign bus.max_latency  = max_q;
`else
  assign bus.last_latency = '0;
  assign bus.max_latency  = '0;
`endif
endmodule
